// File: rtl/hazard_stall_if.sv
// Bundle between the hazard/stall unit and the pipeline: the ID/EX hazard
// inputs, the pipeline enables it drives, and its performance counters.
interface hazard_stall_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_RS;
    logic [4:0]       IFID_RT;
    logic             IFID_UseRS;
    logic             IFID_UseRT;
    logic             IFID_Branch;
    logic             Branch_Taken;
    logic [4:0]       IDEX_WriteReg;
    logic             IDEX_RegWrite;
    logic             IDEX_MemRead;
    logic             Ext_Stall;
    logic             PC_Write;
    logic             IFID_Write;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic [1:0]       Stall_State;
    logic [CNT_W-1:0] Stall_Cycles;
    logic [CNT_W-1:0] Flush_Count;

    modport master (
        output IFID_RS, IFID_RT, IFID_UseRS, IFID_UseRT, IFID_Branch, Branch_Taken,
               IDEX_WriteReg, IDEX_RegWrite, IDEX_MemRead, Ext_Stall,
        input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall_State,
               Stall_Cycles, Flush_Count
    );

    modport slave (
        input  IFID_RS, IFID_RT, IFID_UseRS, IFID_UseRT, IFID_Branch, Branch_Taken,
               IDEX_WriteReg, IDEX_RegWrite, IDEX_MemRead, Ext_Stall,
        output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall_State,
               Stall_Cycles, Flush_Count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand hazard detection with stall FSM, external freeze
// and branch flush. Performance counters are built only with HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_stall_if.slave  hs
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_STALL1 = 2'b01,
        ST_STALL2 = 2'b10,
        ST_FREEZE = 2'b11
    } state_t;

    state_t state_r;
    state_t saved_r;
    state_t state_next_s;
    state_t saved_next_s;

    logic rs_hit_s;
    logic rt_hit_s;
    logic match_s;
    logic need_one_s;
    logic need_two_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic bubble_s;
    logic flush_s;

    // Dependency between the ID operands and the EX destination; $0 never hazards.
    always_comb begin
        rs_hit_s   = hs.IFID_UseRS && (hs.IFID_RS == hs.IDEX_WriteReg);
        rt_hit_s   = hs.IFID_UseRT && (hs.IFID_RT == hs.IDEX_WriteReg);
        match_s    = hs.IDEX_RegWrite && (hs.IDEX_WriteReg != 5'd0) && (rs_hit_s || rt_hit_s);
        need_one_s = match_s && (hs.IDEX_MemRead ^ hs.IFID_Branch);
        need_two_s = match_s && hs.IDEX_MemRead && hs.IFID_Branch;
    end

    // State register; the saved state remembers where to resume after a freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            saved_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
            saved_r <= saved_next_s;
        end
    end

    // Next-state logic; an external freeze overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        saved_next_s = saved_r;
        case (state_r)
            ST_RUN: begin
                if (hs.Ext_Stall) begin
                    state_next_s = ST_FREEZE;
                    saved_next_s = ST_RUN;
                end else if (need_two_s) begin
                    state_next_s = ST_STALL1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STALL1, ST_STALL2: begin
                if (hs.Ext_Stall) begin
                    state_next_s = ST_FREEZE;
                    saved_next_s = state_r;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FREEZE: begin
                if (hs.Ext_Stall) begin
                    state_next_s = ST_FREEZE;
                end else if (saved_r == ST_FREEZE) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = saved_r;
                end
            end
            default: begin
                state_next_s = ST_RUN;
                saved_next_s = ST_RUN;
            end
        endcase
    end

    // Pipeline enables; all quiet while reset is held.
    always_comb begin
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        bubble_s     = 1'b0;
        flush_s      = 1'b0;
        if (!rst_n) begin
            pc_write_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hs.Ext_Stall) begin
                        bubble_s = 1'b0;
                    end else if (need_one_s || need_two_s) begin
                        bubble_s = 1'b1;
                    end else if (hs.Branch_Taken) begin
                        pc_write_s   = 1'b1;
                        ifid_write_s = 1'b1;
                        flush_s      = 1'b1;
                    end else begin
                        pc_write_s   = 1'b1;
                        ifid_write_s = 1'b1;
                    end
                end
                ST_STALL1, ST_STALL2: begin
                    if (hs.Ext_Stall) begin
                        bubble_s = 1'b0;
                    end else begin
                        bubble_s = 1'b1;
                    end
                end
                ST_FREEZE: begin
                    bubble_s = 1'b0;
                end
                default: begin
                    bubble_s = 1'b0;
                end
            endcase
        end
    end

    assign hs.PC_Write    = pc_write_s;
    assign hs.IFID_Write  = ifid_write_s;
    assign hs.IDEX_Bubble = bubble_s;
    assign hs.IFID_Flush  = flush_s;
    assign hs.Stall_State = state_r;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating event counters for bubbles and flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (bubble_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign hs.Stall_Cycles = stall_cnt_r;
    assign hs.Flush_Count  = flush_cnt_r;
`else
    assign hs.Stall_Cycles = {CNT_W{1'b0}};
    assign hs.Flush_Count  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the performance counters.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- IFID_RS  in  5  ID-stage source register RS
- IFID_RT  in  5  ID-stage source register RT
- IFID_UseRS  in  1  ID instruction reads RS
- IFID_UseRT  in  1  ID instruction reads RT
- IFID_Branch  in  1  ID instruction is a branch compared in ID
- Branch_Taken  in  1  branch resolved taken in ID this cycle
- IDEX_WriteReg  in  5  EX-stage destination register
- IDEX_RegWrite  in  1  EX-stage instruction writes a register
- IDEX_MemRead  in  1  EX-stage instruction is a load
- Ext_Stall  in  1  external freeze (memory wait)
- PC_Write  out  1  PC update enable
- IFID_Write  out  1  IF/ID register load enable
- IDEX_Bubble  out  1  insert NOP into ID/EX
- IFID_Flush  out  1  zero the IF/ID register
- Stall_State  out  2  FSM state: 00 RUN, 01 STALL1, 10 STALL2, 11 FREEZE
- Stall_Cycles  out  CNT_W  count of bubble cycles
- Flush_Count  out  CNT_W  count of flushes

Function
REQ-003 SHALL define a match as IDEX_RegWrite=1, IDEX_WriteReg!=0, and ((IFID_UseRS and IFID_RS==IDEX_WriteReg) or (IFID_UseRT and IFID_RT==IDEX_WriteReg)).
REQ-004 SHALL define the required bubbles for a match in RUN:
- load with non-branch consumer: 1
- non-load with branch consumer: 1
- load with branch consumer: 2
- non-load with non-branch consumer: 0
REQ-005 In RUN with 1 or 2 bubbles required, SHALL drive PC_Write=0, IFID_Write=0 and IDEX_Bubble=1 in the same cycle (combinational).
- 1 bubble: next state RUN.
- 2 bubbles: next state STALL1.
REQ-006 In STALL1, SHALL drive PC_Write=0, IFID_Write=0, IDEX_Bubble=1, ignore the IDEX inputs, and go to RUN next cycle.
REQ-007 STALL2 is reserved. If reached, SHALL behave as STALL1 and return to RUN.
REQ-008 On Ext_Stall=1 in any state, SHALL drive PC_Write=0, IFID_Write=0 and IDEX_Bubble=0, and enter FREEZE.
- The pending state is saved and resumed when Ext_Stall falls.
- Hazard evaluation is re-done on resume from RUN.
REQ-009 With no stall in RUN, Branch_Taken=1 SHALL assert IFID_Flush=1 for exactly that cycle, with PC_Write=1.
REQ-010 While any stall or FREEZE is active, SHALL force IFID_Flush=0 and ignore Branch_Taken.
REQ-011 Outside stall/freeze/flush, SHALL drive PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0.
REQ-012 Stall_State SHALL reflect the registered state, with no combinational path from inputs.

Reset
REQ-013 rst_n=0 SHALL asynchronously force Stall_State=RUN, the saved state to RUN, and both counters to 0.
REQ-014 During reset, combinational outputs SHALL be PC_Write=0, IFID_Write=0, IDEX_Bubble=0, IFID_Flush=0.
REQ-015 Reset asserted mid-stall SHALL abandon the stall. After deassertion, normal RUN behaviour SHALL begin on the first clk edge.

Configuration
REQ-016 SHALL use macro HAZARD_PERF_CNT_EN to control the counters.
- Defined: Stall_Cycles increments on each cycle with IDEX_Bubble=1, and Flush_Count increments on each IFID_Flush=1. Both saturate at all-ones.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Verification
REQ-017 Load to $5 in EX; ID add uses RS=$5, UseRS=1 -> one cycle of PC_Write=0, IDEX_Bubble=1; Stall_State stays 00.
REQ-018 Load to $7 in EX; ID beq with RT=$7, Branch=1 -> two bubble cycles; Stall_State 00->01->00; Stall_Cycles +2.
REQ-019 IDEX_WriteReg=0 with RegWrite=1; ID uses RS=0 -> no stall.
REQ-020 Branch_Taken=1 with no hazard -> IFID_Flush=1 for one cycle; Flush_Count +1.
REQ-021 Ext_Stall high 3 cycles during STALL1 -> Stall_State 11, all enables 0, then resumes STALL1 for one cycle, then RUN.
REQ-022 rst_n pulsed low during STALL1 -> Stall_State=00 and counters=0 immediately, without waiting for clk.
